// File: rtl/omsp_spm_cmd_seq.sv
// Command sequencer in front of the SPM control array.
// Takes one protect / unprotect / load-key / read-data command at a time and drives the
// array strobes in order. Each command gets exactly one response pulse.
//
// Ports:
//   mclk, puc_rst_n            clock, asynchronous active-low reset
//   cmd_valid/ready/op/sel/req command handshake and operands (latched on handshake)
//   key_word_valid/ready/word  key word stream, most-significant word first
//   update_spm, enable_spm,
//   spm_select, data_request,
//   write_key, key_in          registered strobes to the array
//   violation, spm_select_valid,
//   requested_data             results from the array
//   resp_valid/err/data        one-cycle response
module omsp_spm_cmd_seq #(
  parameter int unsigned KEY_WORDS   = 8,
  parameter int unsigned KEY_TIMEOUT = 255
) (
  input  logic        mclk,
  input  logic        puc_rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_sel,
  input  logic [2:0]  cmd_req,
  input  logic        key_word_valid,
  input  logic [15:0] key_word,
  output logic        key_word_ready,
  output logic        update_spm,
  output logic        enable_spm,
  output logic [15:0] spm_select,
  output logic [2:0]  data_request,
  output logic        write_key,
  output logic [15:0] key_in,
  input  logic        violation,
  input  logic        spm_select_valid,
  input  logic [15:0] requested_data,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [15:0] resp_data
);

  localparam logic [1:0] OpProtect   = 2'b00;
  localparam logic [1:0] OpLoadKey   = 2'b10;

  localparam int unsigned CntW = $clog2(KEY_WORDS + 1);
  localparam int unsigned TmoW = $clog2(KEY_TIMEOUT + 1);
  localparam logic [CntW-1:0] LastWord = CntW'(KEY_WORDS - 1);
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(KEY_TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StUpd, StChk, StSel, StKey, StRd, StResp} state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [2:0]        req_q, req_d;
  logic [CntW-1:0]   wcnt_q, wcnt_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  // KEY: last word accepted, write pending. RD: request already driven.
  logic              phase_q, phase_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              key_ready_q, key_ready_d;
  logic              update_q, update_d;
  logic              enable_q, enable_d;
  logic [15:0]       select_q, select_d;
  logic [2:0]        dreq_q, dreq_d;
  logic              write_key_q, write_key_d;
  logic [15:0]       key_in_q, key_in_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [15:0]       resp_data_q, resp_data_d;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    req_d        = req_q;
    wcnt_d       = wcnt_q;
    tmo_d        = tmo_q;
    phase_d      = phase_q;
    cmd_ready_d  = cmd_ready_q;
    key_ready_d  = key_ready_q;
    update_d     = update_q;
    enable_d     = enable_q;
    select_d     = select_q;
    dreq_d       = dreq_q;
    write_key_d  = write_key_q;
    key_in_d     = key_in_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_data_d  = resp_data_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          op_d        = cmd_op;
          req_d       = cmd_req;
          wcnt_d      = '0;
          tmo_d       = '0;
          phase_d     = 1'b0;
          if (!cmd_op[1]) begin
            state_d  = StUpd;
            update_d = 1'b1;
            enable_d = (cmd_op == OpProtect);
          end else begin
            state_d  = StSel;
            select_d = cmd_sel;
          end
        end
      end
      StUpd: begin
        update_d = 1'b0;
        enable_d = 1'b0;
        state_d  = StChk;
      end
      StChk: begin
        state_d      = StResp;
        resp_valid_d = 1'b1;
        // Unprotect never reports a violation.
        resp_err_d   = (op_q == OpProtect) && violation;
        resp_data_d  = '0;
      end
      StSel: begin
        if (spm_select_valid) begin
          if (op_q == OpLoadKey) begin
            state_d     = StKey;
            key_ready_d = 1'b1;
          end else begin
            state_d = StRd;
            dreq_d  = req_q;
          end
        end else begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_data_d  = (op_q == OpLoadKey) ? 16'hFFFF : 16'h0000;
        end
      end
      StKey: begin
        write_key_d = 1'b0;
        if (phase_q) begin
          // Final write_key pulse is on the bus this cycle; respond after it.
          state_d      = StResp;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_data_d  = 16'(KEY_WORDS);
        end else if (key_word_valid && key_ready_q) begin
          write_key_d = 1'b1;
          key_in_d    = key_word;
          wcnt_d      = wcnt_q + CntW'(1);
          tmo_d       = '0;
          if (wcnt_q == LastWord) begin
            key_ready_d = 1'b0;
            phase_d     = 1'b1;
          end
        end else if (tmo_q == TmoLast) begin
          key_ready_d  = 1'b0;
          state_d      = StResp;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_data_d  = 16'(wcnt_q);
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StRd: begin
        if (!phase_q) begin
          dreq_d  = '0;
          phase_d = 1'b1;
        end else begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_data_d  = requested_data;
        end
      end
      StResp: begin
        state_d      = StIdle;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_data_d  = '0;
        select_d     = '0;
        dreq_d       = '0;
        key_in_d     = '0;
        cmd_ready_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state_q      <= StIdle;
      op_q         <= '0;
      req_q        <= '0;
      wcnt_q       <= '0;
      tmo_q        <= '0;
      phase_q      <= 1'b0;
      cmd_ready_q  <= 1'b1;
      key_ready_q  <= 1'b0;
      update_q     <= 1'b0;
      enable_q     <= 1'b0;
      select_q     <= '0;
      dreq_q       <= '0;
      write_key_q  <= 1'b0;
      key_in_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      req_q        <= req_d;
      wcnt_q       <= wcnt_d;
      tmo_q        <= tmo_d;
      phase_q      <= phase_d;
      cmd_ready_q  <= cmd_ready_d;
      key_ready_q  <= key_ready_d;
      update_q     <= update_d;
      enable_q     <= enable_d;
      select_q     <= select_d;
      dreq_q       <= dreq_d;
      write_key_q  <= write_key_d;
      key_in_q     <= key_in_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign key_word_ready = key_ready_q;
  assign update_spm     = update_q;
  assign enable_spm     = enable_q;
  assign spm_select     = select_q;
  assign data_request   = dreq_q;
  assign write_key      = write_key_q;
  assign key_in         = key_in_q;
  assign resp_valid     = resp_valid_q;
  assign resp_err       = resp_err_q;
  assign resp_data      = resp_data_q;

endmodule

// File: doc/omsp_spm_cmd_seq.md
Name: omsp_spm_cmd_seq

Overview:
Command sequencer in front of the SPM control array. It accepts one protect, unprotect, key-load or data-read command at a time from the execution unit. It drives the array's update/enable, select, key-write and data-request strobes in the required cycle order. It collects violation, select-valid and requested-data results and returns one response per command.

Parameters:
KEY_WORDS, 8, number of 16-bit words per SPM key (8 = 128 bits).
KEY_TIMEOUT, 255, maximum idle cycles allowed between key words before the load aborts.

Ports:
mclk  in  1  system clock
puc_rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
cmd_op  in  2  00 protect, 01 unprotect, 10 load key, 11 read data
cmd_sel  in  16  SPM selector (ID or address) for load key and read data
cmd_req  in  3  data_request code for read data
key_word_valid  in  1  key word available
key_word  in  16  key word, most-significant word first
key_word_ready  out  1  key word consumed this cycle
update_spm  out  1  to the array
enable_spm  out  1  to the array
spm_select  out  16  to the array
data_request  out  3  to the array
write_key  out  1  to the array
key_in  out  16  to the array
violation  in  1  from the array
spm_select_valid  in  1  from the array
requested_data  in  16  from the array
resp_valid  out  1  one-cycle response pulse
resp_err  out  1  response error flag, valid with resp_valid
resp_data  out  16  response payload, valid with resp_valid

Behaviour:
- Reset: all outputs 0 except cmd_ready=1; state IDLE; internal registers cleared. Reset mid-command aborts immediately with no response. Any partially written key is left as written; the array owns its recovery.
- All outputs are registered. The command and its operands are latched on the cmd_valid & cmd_ready handshake. cmd_* inputs are ignored outside IDLE.
- States: IDLE, UPD, CHK, SEL, KEY, RD, RESP.
- Protect: IDLE -> UPD. UPD drives update_spm=1 and enable_spm=1 for exactly 1 cycle. -> CHK samples violation. -> RESP with resp_err=violation and resp_data=0.
- Unprotect: same path with enable_spm=0. resp_err is always 0.
- Load key: IDLE -> SEL drives spm_select=cmd_sel for 1 cycle, then samples spm_select_valid.
  - If invalid: -> RESP with err=1 and resp_data=16'hFFFF.
  - If valid: -> KEY. key_word_ready=1 while in KEY. Each accepted word drives write_key=1 and key_in=key_word on the next cycle, with spm_select held.
  - The word counter counts 0..KEY_WORDS-1. After the last word -> RESP with err=0 and resp_data=KEY_WORDS.
  - The timeout counter resets on each accepted word. Reaching KEY_TIMEOUT -> RESP with err=1 and resp_data=number of words written.
- Read data: SEL as for load key. If valid: -> RD, which drives data_request=cmd_req for 1 cycle. The following cycle captures requested_data into resp_data. -> RESP with err=0. If invalid: err=1 and resp_data=0.
- RESP: resp_valid=1 for 1 cycle -> IDLE. cmd_ready rises the cycle after RESP, so back-to-back commands have a minimum 1-cycle gap.
- spm_select and data_request return to 0 in IDLE. update_spm and write_key are never asserted together.
- A violation sampled in any state other than CHK is ignored. The SPM control owns violation handling.
- Latencies from handshake to resp_valid:
  - protect/unprotect: 3 cycles.
  - read data: 4 cycles.
  - key load, zero-stall stream: KEY_WORDS+3 cycles.

Test Plan:
- Protect with violation=0 -> update_spm=1 and enable_spm=1 exactly 1 cycle, then resp_valid with err=0, 3 cycles after the handshake. Repeat with violation=1 held in CHK -> err=1.
- Unprotect -> update_spm=1 and enable_spm=0 for 1 cycle; resp err=0.
- Load key to a valid SPM with 8 words 16'h0001..16'h0008 streamed with no gaps -> 8 write_key pulses with key_in in that order; resp err=0, data=8.
- Load key with spm_select_valid=0 -> no write_key pulse; resp err=1, data=16'hFFFF.
- Load key: stall after 3 words for KEY_TIMEOUT cycles -> resp err=1, data=3; cmd_ready returns.
- Read data cmd_req=3'b010, requested_data=16'hBEEF -> data_request=2 for 1 cycle; resp data=16'hBEEF.
- Assert puc_rst_n=0 mid key load -> outputs cleared immediately, no resp_valid, cmd_ready=1 after release.
